reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 49 ++++
 tb/tb_reg_file.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Multi-ported register file: two combinational read ports and one clocked write port.
// An asynchronous reset clears every entry at once, with no clock required.
module reg_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Only the addressed entry can change.
  // A read of that entry keeps returning the old word until the clock edge.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (write_enable && (WA == ADDR_W'(i))) begin
        mem_d[i] = data_in;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign data_out1 = mem_q[RA1];
  assign data_out2 = mem_q[RA2];

endmodule

// File: tb/tb_reg_file.sv
// Directed and randomized bench for reg_file.
// Read data is checked against an array model that the bench updates on each clock edge.
module tb_reg_file;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic [DATA_W-1:0] data_out1, data_out2;
  logic [ADDR_W-1:0] ra1, ra2, wa;
  logic [DATA_W-1:0] data_in;
  logic              clk, reset, write_enable;
  logic              clk_en;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  int total = 0;
  int bad   = 0;

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .data_out1   (data_out1),
    .data_out2   (data_out2),
    .RA1         (ra1),
    .RA2         (ra2),
    .WA          (wa),
    .data_in     (data_in),
    .clk         (clk),
    .reset       (reset),
    .write_enable(write_enable)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // scoreboard: queue the model's view of both ports, then compare
  task automatic read_check(input string tag, input logic [ADDR_W-1:0] a1,
                            input logic [ADDR_W-1:0] a2);
    ra1 = a1;
    ra2 = a2;
    #1;
    exp_q.push_back(model[a1]);
    exp_q.push_back(model[a2]);
    chk({tag, "_p1"}, data_out1, exp_q.pop_front());
    chk({tag, "_p2"}, data_out2, exp_q.pop_front());
  endtask

  // driver: set up a write on the falling edge, then commit on the rising edge
  task automatic drive_cycle(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic we);
    @(negedge clk);
    wa           = a;
    data_in      = d;
    write_enable = we;
    @(posedge clk);
    if (we && !reset) model[a] = d;
    #1;
  endtask

  initial begin
    clk_en       = 1'b0;
    reset        = 1'b0;
    write_enable = 1'b0;
    wa           = '0;
    data_in      = '0;
    ra1          = '0;
    ra2          = '0;
    model_clear();

    // reset pulse with the clock stopped
    #3 reset = 1'b1;
    #2 reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) read_check("rst_idle", ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));

    clk_en = 1'b1;

    // write 32 to entry 10 while reading 4 and 6
    ra1 = 4'd4;
    ra2 = 4'd6;
    drive_cycle(4'd10, 8'd32, 1'b1);
    read_check("untouched_4_6", 4'd4, 4'd6);
    read_check("wr10", 4'd10, 4'd6);

    // write_enable low keeps entry 10 intact
    drive_cycle(4'd10, 8'd99, 1'b0);
    read_check("nowe_3_5", 4'd3, 4'd5);
    read_check("nowe_10", 4'd3, 4'd10);

    // read during write on the same entry: old data before the edge, new after
    @(negedge clk);
    ra1 = 4'd7;
    ra2 = 4'd7;
    wa = 4'd7;
    data_in = 8'hA5;
    write_enable = 1'b1;
    #1;
    chk("rdw_before_p1", data_out1, 8'h00);
    chk("rdw_before_p2", data_out2, 8'h00);
    @(posedge clk);
    #1;
    chk("rdw_after_p1", data_out1, 8'hA5);
    chk("rdw_after_p2", data_out2, 8'hA5);
    model[7] = 8'hA5;

    // entry 0 is an ordinary register
    drive_cycle(4'd0, 8'hFF, 1'b1);
    read_check("entry0", 4'd0, 4'd0);

    // fill every entry with a distinct value
    for (int i = 0; i < DEPTH; i++) drive_cycle(ADDR_W'(i), DATA_W'(8'h10 + i), 1'b1);
    for (int i = 0; i < DEPTH; i++) read_check("fill", ADDR_W'(i), ADDR_W'((i + 5) % DEPTH));

    // asynchronous reset between edges clears everything immediately
    @(negedge clk);
    write_enable = 1'b0;
    #2;
    ra1 = 4'd3;
    ra2 = 4'd12;
    reset = 1'b1;
    #1;
    chk("async_rst_p1", data_out1, 8'h00);
    chk("async_rst_p2", data_out2, 8'h00);
    model_clear();

    // a write attempted while reset is high is dropped
    drive_cycle(4'd3, 8'h77, 1'b1);
    read_check("wr_in_reset", 4'd3, 4'd3);
    @(negedge clk);
    write_enable = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) read_check("post_rst", ADDR_W'(i), ADDR_W'(i));

    // first edge after reset release writes normally
    drive_cycle(4'd3, 8'h5A, 1'b1);
    read_check("first_wr", 4'd3, 4'd2);

    // randomized traffic, checking reads both before and after each edge
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      wa           = ADDR_W'($urandom_range(0, DEPTH - 1));
      data_in      = DATA_W'($urandom);
      write_enable = ($urandom_range(0, 3) != 0);
      read_check("rnd_pre", ADDR_W'($urandom_range(0, DEPTH - 1)), wa);
      @(posedge clk);
      if (write_enable) model[wa] = data_in;
      #1;
      read_check("rnd_post", wa, ADDR_W'($urandom_range(0, DEPTH - 1)));
    end

    clk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
